// File: rtl/sram_uart_transmit_interface_pkg.sv
// Shared types and constants for the SRAM -> UART dump path.
// Header ROM is only used when SRAM_UART_PPM_HEADER_EN is defined.
package sram_uart_transmit_interface_pkg;

  typedef enum logic [3:0] {
    S_ST_IDLE,
    S_ST_HEADER,
    S_ST_READ_WAIT,
    S_ST_SEND_HI,
    S_ST_WAIT_HI,
    S_ST_SEND_LO,
    S_ST_WAIT_LO,
    S_ST_NEXT,
    S_ST_DONE
  } SRAM_UART_state_type;

  localparam logic [17:0] SRAM_MAX_ADDR = 18'h3FFFF;
  localparam logic [3:0]  HEADER_LAST   = 4'd14;

  // "P6\n320 240\n255\n"
  function automatic logic [7:0] header_rom(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h0A;
    case (idx)
      4'd0:  b = 8'h50;
      4'd1:  b = 8'h36;
      4'd2:  b = 8'h0A;
      4'd3:  b = 8'h33;
      4'd4:  b = 8'h32;
      4'd5:  b = 8'h30;
      4'd6:  b = 8'h20;
      4'd7:  b = 8'h32;
      4'd8:  b = 8'h34;
      4'd9:  b = 8'h30;
      4'd10: b = 8'h0A;
      4'd11: b = 8'h32;
      4'd12: b = 8'h35;
      4'd13: b = 8'h35;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sram_uart_transmit_interface_uart.sv
// 8N1 serializer: baud counter, bit counter and 10-bit frame shifter.
// Empty drops the cycle after Load and rises the cycle after the stop bit.
module UART_transmit_controller #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Clear,
  input  logic       Load,
  input  logic [7:0] TX_data,
  output logic       Empty,
  output logic       UART_TX_O
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);

  logic          active;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      frame    <= '1;
    end else if (Clear) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      frame    <= '1;
    end else if (!active) begin
      if (Load) begin
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        frame    <= {1'b1, TX_data, 1'b0};
      end
    end else if (baud_cnt == BW'(CLKS_PER_BIT - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;
        frame  <= '1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        frame   <= {1'b1, frame[9:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign Empty     = !active;
  assign UART_TX_O = active ? frame[0] : 1'b1;

endmodule

// File: rtl/sram_uart_transmit_interface.sv
// Streams SRAM words [Start..End] out the UART, high byte first.
// Define SRAM_UART_PPM_HEADER_EN to prepend the 15-byte PPM header.
module sram_uart_transmit_interface
  import sram_uart_transmit_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Initialize,
  input  logic        Enable,
  input  logic [17:0] Start_address,
  input  logic [17:0] End_address,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int LW = $clog2(SRAM_READ_LATENCY + 2);

  SRAM_UART_state_type state, state_n;

  logic [17:0]   end_addr;
  logic [15:0]   word;
  logic [LW-1:0] lat_cnt;
  logic          load;
  logic [7:0]    tx_data;
  logic          empty;
  logic          last;
  logic          lat_hit;
`ifdef SRAM_UART_PPM_HEADER_EN
  logic [3:0]    hdr_idx;
`endif

  assign last = (SRAM_address == end_addr) ||
                (SRAM_address == SRAM_MAX_ADDR);
  assign lat_hit = (lat_cnt == LW'(SRAM_READ_LATENCY));

  always_comb begin
    state_n = state;
    load    = 1'b0;
    tx_data = word[15:8];
    unique case (state)
      S_ST_IDLE:
        if (Enable) begin
          if (End_address < Start_address)
            state_n = S_ST_DONE;
          else
`ifdef SRAM_UART_PPM_HEADER_EN
            state_n = S_ST_HEADER;
`else
            state_n = S_ST_READ_WAIT;
`endif
        end
`ifdef SRAM_UART_PPM_HEADER_EN
      S_ST_HEADER:
        if (empty) begin
          load    = 1'b1;
          tx_data = header_rom(hdr_idx);
          if (hdr_idx == HEADER_LAST)
            state_n = S_ST_READ_WAIT;
        end
`endif
      S_ST_READ_WAIT:
        if (lat_hit) state_n = S_ST_SEND_HI;
      S_ST_SEND_HI:
        if (empty) begin
          load    = 1'b1;
          state_n = S_ST_WAIT_HI;
        end
      S_ST_WAIT_HI:
        if (empty) state_n = S_ST_SEND_LO;
      S_ST_SEND_LO:
        if (empty) begin
          load    = 1'b1;
          tx_data = word[7:0];
          state_n = S_ST_NEXT;
        end
      // next word is fetched while the low byte is still shifting out
      S_ST_NEXT:
        state_n = last ? S_ST_WAIT_LO : S_ST_READ_WAIT;
      S_ST_WAIT_LO:
        if (empty) state_n = S_ST_DONE;
      S_ST_DONE:
        state_n = S_ST_IDLE;
      default:
        state_n = S_ST_IDLE;
    endcase
    if (Initialize) begin
      state_n = S_ST_IDLE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_ST_IDLE;
      SRAM_address <= '0;
      end_addr     <= '0;
      word         <= '0;
      lat_cnt      <= '0;
`ifdef SRAM_UART_PPM_HEADER_EN
      hdr_idx      <= '0;
`endif
    end else if (Initialize) begin
      state        <= S_ST_IDLE;
      SRAM_address <= '0;
      end_addr     <= '0;
      word         <= '0;
      lat_cnt      <= '0;
`ifdef SRAM_UART_PPM_HEADER_EN
      hdr_idx      <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        S_ST_IDLE:
          if (Enable) begin
            SRAM_address <= Start_address;
            end_addr     <= End_address;
            lat_cnt      <= '0;
`ifdef SRAM_UART_PPM_HEADER_EN
            hdr_idx      <= '0;
`endif
          end
`ifdef SRAM_UART_PPM_HEADER_EN
        S_ST_HEADER:
          if (load) hdr_idx <= hdr_idx + 4'd1;
`endif
        S_ST_READ_WAIT:
          if (lat_hit) word <= SRAM_read_data;
          else lat_cnt <= lat_cnt + 1'b1;
        S_ST_NEXT:
          if (!last) begin
            SRAM_address <= SRAM_address + 18'd1;
            lat_cnt      <= '0;
          end
        default: ;
      endcase
    end
  end

  UART_transmit_controller #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Clear    (Initialize),
    .Load     (load),
    .TX_data  (tx_data),
    .Empty    (empty),
    .UART_TX_O(UART_TX_O)
  );

  assign SRAM_we_n = 1'b1;
  assign Busy      = (state != S_ST_IDLE) && (state != S_ST_DONE);
  assign Done      = (state == S_ST_DONE);

endmodule

// File: tb/tb_sram_uart_transmit_interface.sv
// Self-checking bench: UART line decoder, SRAM model and byte-stream model.
// Honours SRAM_UART_PPM_HEADER_EN when the design is built with it.
module tb_sram_uart_transmit_interface;

  localparam int CPB = 4;
  localparam int LAT = 2;

  logic        Clock;
  logic        Resetn;
  logic        Initialize;
  logic        Enable;
  logic [17:0] Start_address;
  logic [17:0] End_address;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  sram_uart_transmit_interface #(
    .CLKS_PER_BIT(CPB),
    .SRAM_READ_LATENCY(LAT)
  ) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .Initialize    (Initialize),
    .Enable        (Enable),
    .Start_address (Start_address),
    .End_address   (End_address),
    .SRAM_address  (SRAM_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_we_n     (SRAM_we_n),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int we_err = 0;
  int frame_err = 0;

  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd1, rd2;
  logic [7:0]  rxq [$];
  int          rxt [$];
  logic [7:0]  hdr [15] = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30,
                            8'h20, 8'h32, 8'h34, 8'h30, 8'h0A, 8'h32,
                            8'h35, 8'h35, 8'h0A};
  bit          hdr_on;

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'(a * 18'd40503 + 18'd4951);
  endfunction

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    rd1 <= mem_rd(SRAM_address);
    rd2 <= rd1;
  end
  assign SRAM_read_data = rd2;

  always @(negedge Clock) begin
    if (SRAM_we_n !== 1'b1) we_err++;
    if (Done === 1'b1) done_cnt++;
  end

  // UART line decoder, sampling mid-bit
  initial begin
    logic [7:0] by;
    int t0;
    forever begin
      @(negedge Clock);
      if (Resetn === 1'b1 && UART_TX_O === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge Clock);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge Clock);
          by[b] = UART_TX_O;
        end
        repeat (CPB) @(negedge Clock);
        if (UART_TX_O !== 1'b1) frame_err++;
        rxq.push_back(by);
        rxt.push_back(t0);
      end
    end
  end

  task automatic check(input string nm, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic run_xfer(input logic [17:0] s, input logic [17:0] e,
                          input bit poke, input int exp_words);
    logic [7:0] exp_q [$];
    int d0, t_en, n, lim, exp_bytes;
    exp_q.delete();
    if (e >= s) begin
      if (hdr_on)
        for (int i = 0; i < 15; i++) exp_q.push_back(hdr[i]);
      for (longint a = s; a <= e; a++) begin
        exp_q.push_back(mem_rd(18'(a)) >> 8);
        exp_q.push_back(mem_rd(18'(a)) & 16'hFF);
      end
    end
    exp_bytes = 2 * exp_words + ((hdr_on && exp_words > 0) ? 15 : 0);
    rxq.delete();
    rxt.delete();
    d0 = done_cnt;
    @(negedge Clock);
    Start_address = s;
    End_address = e;
    Enable = 1'b1;
    @(negedge Clock);
    Enable = 1'b0;
    t_en = cyc;
    Start_address = 18'($urandom);
    End_address = 18'($urandom);
    lim = 50 * (exp_q.size() + 2) + 50;
    n = 0;
    if (poke) begin
      repeat (10) @(negedge Clock);
      n = 10;
      Start_address = 18'h5;
      End_address = 18'h9;
      Enable = 1'b1;
      @(negedge Clock);
      Enable = 1'b0;
      n++;
    end
    while (Done !== 1'b1 && n < lim) begin
      @(negedge Clock);
      n++;
    end
    check("done_seen", Done === 1'b1, 1);
    check("busy_with_done", Busy, 0);
    if (exp_q.size() == 0)
      check("empty_done_delay", (cyc - t_en + 1) <= 2, 1);
    if (exp_q.size() == 2 && rxt.size() > 0)
      check("done_after_start", (cyc - rxt[0]) inside {[78:90]}, 1);
    check("addr_hold", SRAM_address, (e >= s) ? e : s);
    @(negedge Clock);
    check("done_pulse_1cyc", Done, 0);
    repeat (5) @(negedge Clock);
    check("done_count", done_cnt - d0, 1);
    check("byte_count", rxq.size(), exp_q.size());
    check("byte_count_tbl", rxq.size(), exp_bytes);
    for (int i = 0; i < exp_q.size() && i < rxq.size(); i++)
      check($sformatf("byte[%0d]", i), rxq[i], exp_q[i]);
    for (int i = 1; i < rxt.size(); i++)
      check("frame_gap", (rxt[i] - rxt[i-1] - 10 * CPB) <= 2, 1);
  endtask

  typedef struct {
    logic [17:0] s;
    logic [17:0] e;
    bit          poke;
    int          words;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    logic [17:0] s, e;
    int len;
`ifdef SRAM_UART_PPM_HEADER_EN
    hdr_on = 1'b1;
`else
    hdr_on = 1'b0;
`endif
    mem[18'h00100] = 16'hA55A;
    mem[18'h3FFFE] = 16'h1234;
    mem[18'h3FFFF] = 16'hABCD;
    mem[18'h00000] = 16'hFFFF;
    vecs[0] = '{18'h00100, 18'h00100, 1'b0, 1};
    vecs[1] = '{18'h3FFFE, 18'h3FFFF, 1'b0, 2};
    vecs[2] = '{18'h00010, 18'h0000F, 1'b0, 0};
    vecs[3] = '{18'h00020, 18'h00022, 1'b1, 3};
    vecs[4] = '{18'h3FFFF, 18'h3FFFF, 1'b0, 1};
    vecs[5] = '{18'h00000, 18'h00000, 1'b0, 1};

    Resetn = 1'b0;
    Initialize = 1'b0;
    Enable = 1'b0;
    Start_address = '0;
    End_address = '0;
    repeat (3) @(negedge Clock);
    check("rst_addr", SRAM_address, 0);
    check("rst_we_n", SRAM_we_n, 1);
    check("rst_tx", UART_TX_O, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    for (int i = 0; i < 6; i++)
      run_xfer(vecs[i].s, vecs[i].e, vecs[i].poke, vecs[i].words);

    // abort in the middle of the second frame's first data bit
    rxq.delete();
    rxt.delete();
    n = done_cnt;
    @(negedge Clock);
    Start_address = 18'h00200;
    End_address = 18'h00201;
    Enable = 1'b1;
    @(negedge Clock);
    Enable = 1'b0;
    len = 0;
    while (rxq.size() < 1 && len < 2000) begin
      @(negedge Clock);
      len++;
    end
    while (UART_TX_O !== 1'b0 && len < 2000) begin
      @(negedge Clock);
      len++;
    end
    check("abort_reach_byte2", len < 2000, 1);
    repeat (6) @(negedge Clock);
    Initialize = 1'b1;
    Enable = 1'b1;
    Start_address = 18'h00300;
    End_address = 18'h00300;
    @(posedge Clock);
    #1;
    check("abort_tx_high", UART_TX_O, 1);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_addr", SRAM_address, 0);
    @(negedge Clock);
    Initialize = 1'b0;
    Enable = 1'b0;
    repeat (60) @(negedge Clock);
    check("abort_no_done", done_cnt - n, 0);
    check("abort_idle", Busy, 0);
    run_xfer(18'h00300, 18'h00300, 1'b0, 1);

    // randomized ranges against the byte-stream model
    for (int k = 0; k < 6; k++) begin
      s = 18'($urandom);
      len = $urandom_range(0, 2);
      e = (s > 18'h3FFFF - 18'(len)) ? 18'h3FFFF : s + 18'(len);
      if (k == 2 && s != 0) e = s - 18'd1;
      for (longint a = s; a <= e; a++) mem[18'(a)] = 16'($urandom);
      run_xfer(s, e, 1'b0, (e >= s) ? int'(e - s) + 1 : 0);
    end

    check("we_n_always_high", we_err, 0);
    check("framing_errors", frame_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
